// File: rtl/rec2pol_pkg.sv
// Shared types and helpers for the rec2pol scheduler slice.
package rec2pol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_LATENCY = 33;

    // Bits needed to encode values 0..n-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/rec2pol_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping upward.
module rec2pol_rr_arbiter
    import rec2pol_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] index,
    output logic            any
);

    always_comb begin
        logic [ID_W-1:0] idx;
        grant = '0;
        index = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                index      = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rec2pol_scheduler.sv
// Shares one fixed-latency rec2pol core among NREQ requesters, round-robin,
// returning each result tagged with the owning requester index.
module rec2pol_scheduler
    import rec2pol_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ID_W    = clog2_min1(NREQ),
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MOD_W   = 32,
    parameter int unsigned ANG_W   = 32,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned CNT_W   = clog2_min1(LATENCY + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    output logic [NREQ-1:0]        req_ready,
    output logic                   core_start,
    output logic [DATA_W-1:0]      core_x,
    output logic [DATA_W-1:0]      core_y,
    input  logic [MOD_W-1:0]       core_mod,
    input  logic [ANG_W-1:0]       core_angle,
    output logic                   out_valid,
    output logic [ID_W-1:0]        out_id,
    output logic [MOD_W-1:0]       out_mod,
    output logic [ANG_W-1:0]       out_angle,
    output logic                   busy
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  cnt;

    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] sel_x;
    logic [DATA_W-1:0] sel_y;

    rec2pol_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .index (gnt_idx),
        .any   (gnt_any)
    );

    // Accept pulses exist only while idle; the grant itself is combinational.
    assign req_ready = (state == ST_IDLE) ? gnt : '0;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_x = req_x[i*DATA_W +: DATA_W];
                sel_y = req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            id_q       <= '0;
            cnt        <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_mod    <= '0;
            out_angle  <= '0;
            busy       <= 1'b0;
        end else begin
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        core_x     <= sel_x;
                        core_y     <= sel_y;
                        id_q       <= gnt_idx;
                        ptr        <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // cnt == LATENCY-1 marks cycle S+LATENCY, when core outputs are valid.
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LATENCY - 1)) begin
                        out_mod   <= core_mod;
                        out_angle <= core_angle;
                        out_id    <= id_q;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
